sad_operand_loader: RTL and testbench
=====================================

// Module: sad_operand_loader
// PURPOSE
//  Writer side of the SAD operand SRAM port. Accepts an 8-bit byte stream (valid/ready), fills
//  operand memory A, then operand memory B, then pulses Go to the SAD engine. Owns the SRAM
//  write port while Busy=1; the top-level mux gives the port to SAD when Busy=0.
// PARAMETERS
//  A_WIDTH    15           operand SRAM address width
//  D_WIDTH    8            operand SRAM data width (one stream beat = one word)
//  NUM_WORDS  2**A_WIDTH   words written per memory (sims may override, e.g. 16)
// PORTS
//  Clk        in   1        single clock, all state on rising edge
//  Rst_n      in   1        asynchronous, active-low reset
//  Start      in   1        1-cycle request to begin a load; honoured only in IDLE
//  In_Data    in   D_WIDTH  stream data
//  In_Valid   in   1        stream data valid
//  In_Ready   out  1        loader can accept a beat this cycle
//  Mem_Addr   out  A_WIDTH  write address, shared by A and B
//  Mem_Di     out  D_WIDTH  write data (= In_Data)
//  A_RW/A_En  out  1/1      memory A: RW=1 write, En=1 access
//  B_RW/B_En  out  1/1      memory B: same encoding
//  Busy       out  1        loader owns the SRAM port
//  Go         out  1        1-cycle start pulse to SAD
//  Err        out  1        checksum mismatch, sticky until next Start (LOADER_CHECKSUM_EN only)
// BEHAVIOUR
//  Reset (async, Rst_n=0): state IDLE, address counter 0, all outputs 0, checksum accumulator 0.
//  States: IDLE -> LOAD_A -> LOAD_B -> [CSUM_HI -> CSUM_LO] -> GO -> IDLE.
//  - IDLE: In_Ready=0, Busy=0. Start=1 -> LOAD_A, counter=0, Err cleared.
//  - LOAD_A/LOAD_B: In_Ready=1 (Moore, state-decoded), Busy=1. Beat = In_Valid & In_Ready.
//    On a beat: X_En=X_RW=1 in that same cycle (combinational), Mem_Addr=counter, Mem_Di=In_Data;
//    SRAM captures on the rising edge. Counter increments per beat; no beat -> no write, hold.
//  - Last beat (counter==NUM_WORDS-1): counter wraps to 0; LOAD_A -> LOAD_B; LOAD_B -> GO
//    (or CSUM_HI when checksum compiled in). Never write beyond NUM_WORDS-1.
//  - GO: Go=1 for exactly one cycle, Busy=1, In_Ready=0 -> IDLE. Go asserts the cycle after the
//    final B write (or final checksum byte).
//  - Start outside IDLE is ignored, including on the same cycle as the last beat.
//  - In_Valid in IDLE/GO is not consumed (In_Ready=0); data stays with the source.
//  - Rst_n low mid-load: immediate return to IDLE; partially written memory contents are left
//    as-is; no Go is issued.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: a 16-bit accumulator sums (mod 2^16, zero-extended) every A and
//   B byte. After LOAD_B, two further beats are accepted: CSUM_HI (bits 15:8) then CSUM_LO
//   (bits 7:0); no SRAM writes during them. Match -> GO. Mismatch -> Err=1, no Go, -> IDLE.
//  LOADER_CHECKSUM_EN undefined: CSUM states, accumulator and compare are absent; LOAD_B -> GO
//   directly; Err tied 0.
// STRUCTURE
//  sad_pkg: A_WIDTH/D_WIDTH defaults, RW_WRITE/RW_READ encodings, state enum encoding.
//  One sub-module: sad_load_counter (A_WIDTH counter with inc, clear, terminal-count flag).
//  FSM, write-enable decode and checksum logic stay in this module.
// TESTING (NUM_WORDS=16 unless stated)
//  1. Reset then idle: all outputs 0; In_Valid=1 for 10 cycles -> In_Ready stays 0, no X_En.
//  2. Start; 32 back-to-back beats 0x00..0x1F -> A[0..15]=0x00..0x0F, B[0..15]=0x10..0x1F;
//     Go=1 exactly one cycle after beat 32; Busy falls with Go.
//  3. Same data with In_Valid toggled 1-0 -> identical memory contents, no write on idle
//     cycles, Go once.
//  4. Start pulsed again during LOAD_B and on the last beat -> ignored, single Go, counter
//     unaffected.
//  5. Rst_n=0 after 5 A beats -> all outputs 0 asynchronously; next Start reloads from addr 0.
//  6. LOADER_CHECKSUM_EN, 32 bytes all 0xFF: trailer 0x1F,0xE0 -> Go, Err=0; trailer
//     0x1F,0xE1 -> no Go, Err=1 until next Start. NUM_WORDS=32768 smoke run: Go after 65536
//     beats.

Source files
------------

// File: rtl/sad_operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// sad_operand_loader_pkg
// Shared definitions for the SAD operand loader slice: default SRAM geometry,
// read/write encoding of the operand SRAM RW pins, loader FSM state encoding and
// the checksum accumulate helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sad_operand_loader_pkg;

    // Default operand SRAM geometry.
    localparam int unsigned A_WIDTH_DEF = 15;
    localparam int unsigned D_WIDTH_DEF = 8;

    // Operand SRAM RW pin encoding.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Checksum geometry: 16-bit sum sent as two trailer bytes, high byte first.
    localparam int unsigned CSUM_WIDTH = 16;
    localparam int unsigned CSUM_BYTE  = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoadA  = 3'd1,
        StLoadB  = 3'd2,
        StCsumHi = 3'd3,
        StCsumLo = 3'd4,
        StGo     = 3'd5
    } load_state_e;

    // Modulo-2^16 accumulate of a zero-extended stream word.
    function automatic logic [CSUM_WIDTH-1:0] csum_add(input logic [CSUM_WIDTH-1:0] acc,
                                                       input logic [CSUM_WIDTH-1:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/sad_operand_loader_if.sv
// -----------------------------------------------------------------------------
// sad_operand_loader_if
// Bundles the loader's control, byte-stream and SRAM write-port signals.
//   Start                 request to begin a load
//   In_Data/In_Valid      byte stream from the source
//   In_Ready              loader accepts a beat this cycle
//   Mem_Addr/Mem_Di       shared write address/data for memories A and B
//   A_RW/A_En, B_RW/B_En  per-memory write strobes (RW=1 write, En=1 access)
//   Busy, Go, Err         port ownership, SAD start pulse, checksum error
// Modports: master = loader side, slave = environment (source, SRAMs, SAD).
// -----------------------------------------------------------------------------
interface sad_operand_loader_if
    import sad_operand_loader_pkg::*;
#(
    parameter int unsigned A_WIDTH = A_WIDTH_DEF,
    parameter int unsigned D_WIDTH = D_WIDTH_DEF
) ();

    logic               Start;
    logic [D_WIDTH-1:0] In_Data;
    logic               In_Valid;
    logic               In_Ready;
    logic [A_WIDTH-1:0] Mem_Addr;
    logic [D_WIDTH-1:0] Mem_Di;
    logic               A_RW;
    logic               A_En;
    logic               B_RW;
    logic               B_En;
    logic               Busy;
    logic               Go;
    logic               Err;

    modport master (
        input  Start, In_Data, In_Valid,
        output In_Ready, Mem_Addr, Mem_Di, A_RW, A_En, B_RW, B_En, Busy, Go, Err
    );

    modport slave (
        output Start, In_Data, In_Valid,
        input  In_Ready, Mem_Addr, Mem_Di, A_RW, A_En, B_RW, B_En, Busy, Go, Err
    );

endinterface

// File: rtl/sad_operand_loader_counter.sv
// -----------------------------------------------------------------------------
// sad_load_counter
// Write-address counter for the operand loader. Counts 0..NUM_WORDS-1 and wraps
// to 0 on an increment at terminal count.
//   Clk       clock
//   Rst_n     asynchronous active-low reset (count -> 0)
//   clr_i     synchronous clear (priority over inc_i)
//   inc_i     advance by one
//   count_o   current address
//   tc_o      count_o == NUM_WORDS-1
// -----------------------------------------------------------------------------
module sad_load_counter
    import sad_operand_loader_pkg::*;
#(
    parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
    parameter int unsigned NUM_WORDS = 2 ** A_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [A_WIDTH-1:0] count_o,
    output logic               tc_o
);

    localparam logic [A_WIDTH-1:0] LastAddr = A_WIDTH'(NUM_WORDS - 1);

    logic [A_WIDTH-1:0] count_q, count_d;

    assign tc_o    = (count_q == LastAddr);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = tc_o ? '0 : count_q + A_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sad_operand_loader.sv
// -----------------------------------------------------------------------------
// sad_operand_loader
// Writer side of the SAD operand SRAM port. Takes a valid/ready byte stream,
// fills operand memory A then operand memory B (NUM_WORDS words each, shared
// address), then pulses Go for one cycle. Busy marks ownership of the SRAM port.
//   Clk      clock, all state on rising edge
//   Rst_n    asynchronous active-low reset
//   bus      sad_operand_loader_if.master: Start, stream in, SRAM write port,
//            Busy/Go/Err status
// Build option: define LOADER_CHECKSUM_EN to accept a two-byte 16-bit checksum
// trailer (high byte first) after memory B; a mismatch sets Err (sticky until
// the next Start) and suppresses Go. Undefined: no trailer, Err tied low.
// -----------------------------------------------------------------------------
module sad_operand_loader
    import sad_operand_loader_pkg::*;
#(
    parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
    parameter int unsigned D_WIDTH   = D_WIDTH_DEF,
    parameter int unsigned NUM_WORDS = 2 ** A_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    sad_operand_loader_if.master bus
);

    load_state_e        state_q, state_d;
    logic [A_WIDTH-1:0] count;
    logic               tc;
    logic               in_ready;
    logic               busy;
    logic               go;
    logic               wr_a;
    logic               wr_b;
    logic               beat;
    logic               cnt_clr;
    logic               cnt_inc;
    logic [D_WIDTH-1:0] mem_di;

`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_WIDTH-1:0] acc_q, acc_d;
    logic [CSUM_BYTE-1:0]  csum_hi_q, csum_hi_d;
    logic                  err_q, err_d;
    logic                  csum_ok;
`endif

    assign beat    = bus.In_Valid & in_ready;
    assign cnt_clr = (state_q == StIdle) & bus.Start;
    assign cnt_inc = wr_a | wr_b;

    sad_load_counter #(
        .A_WIDTH   (A_WIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_counter (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (count),
        .tc_o    (tc)
    );

    // ---------------------------------------------------------------- state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) state_d = StLoadA;
            end
            StLoadA: begin
                if (beat && tc) state_d = StLoadB;
            end
            StLoadB: begin
`ifdef LOADER_CHECKSUM_EN
                if (beat && tc) state_d = StCsumHi;
`else
                if (beat && tc) state_d = StGo;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            StCsumHi: begin
                if (beat) state_d = StCsumLo;
            end
            StCsumLo: begin
                // A bad trailer drops straight back to idle so no Go is issued.
                if (beat) state_d = csum_ok ? StGo : StIdle;
            end
`endif
            StGo: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Write strobes use In_Valid directly: In_Ready is already implied by the
    // load states, and this keeps the decode free of a loop through beat.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        go       = 1'b0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StLoadA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                wr_a     = bus.In_Valid;
            end
            StLoadB: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                wr_b     = bus.In_Valid;
            end
            StCsumHi, StCsumLo: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StGo: begin
                busy = 1'b1;
                go   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Data is zeroed off-beat so the port idles at all-zero.
    assign mem_di       = (wr_a | wr_b) ? bus.In_Data : '0;
    assign bus.Mem_Di   = mem_di;
    assign bus.Mem_Addr = count;
    assign bus.A_En     = wr_a;
    assign bus.A_RW     = wr_a ? RW_WRITE : RW_READ;
    assign bus.B_En     = wr_b;
    assign bus.B_RW     = wr_b ? RW_WRITE : RW_READ;
    assign bus.In_Ready = in_ready;
    assign bus.Busy     = busy;
    assign bus.Go       = go;

`ifdef LOADER_CHECKSUM_EN
    // ---------------------------------------------------------------- checksum
    assign csum_ok = ({csum_hi_q, bus.In_Data[CSUM_BYTE-1:0]} == acc_q);

    always_comb begin
        acc_d     = acc_q;
        csum_hi_d = csum_hi_q;
        err_d     = err_q;
        if (cnt_clr) begin
            acc_d = '0;
            err_d = 1'b0;
        end else if (wr_a || wr_b) begin
            acc_d = csum_add(acc_q, CSUM_WIDTH'(bus.In_Data));
        end
        if ((state_q == StCsumHi) && beat) begin
            csum_hi_d = bus.In_Data[CSUM_BYTE-1:0];
        end
        if ((state_q == StCsumLo) && beat && !csum_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q     <= '0;
            csum_hi_q <= '0;
            err_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            csum_hi_q <= csum_hi_d;
            err_q     <= err_d;
        end
    end

    assign bus.Err = err_q;
`else
    assign bus.Err = 1'b0;
`endif

endmodule

// File: tb/tb_sad_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_sad_operand_loader
// Self-checking bench for sad_operand_loader with NUM_WORDS=16. Memories A and B
// are modelled as byte arrays filled from the write strobes; every load is
// compared against the byte list that was streamed in.
// -----------------------------------------------------------------------------
module tb_sad_operand_loader;
    import sad_operand_loader_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst_n;

    always #5 Clk = ~Clk;

    sad_operand_loader_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

    sad_operand_loader #(
        .A_WIDTH   (AW),
        .D_WIDTH   (DW),
        .NUM_WORDS (NW)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    int n_go     = 0;
    logic [7:0] mem_a [NW];
    logic [7:0] mem_b [NW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // SRAM and SAD stand-ins: record writes and Go pulses.
    always @(posedge Clk) begin
        if (bus.A_En && bus.A_RW) begin
            check("wr_a_addr_in_range", 32'(bus.Mem_Addr < AW'(NW)), 1);
            mem_a[bus.Mem_Addr[3:0]] <= bus.Mem_Di;
            n_writes <= n_writes + 1;
        end
        if (bus.B_En && bus.B_RW) begin
            check("wr_b_addr_in_range", 32'(bus.Mem_Addr < AW'(NW)), 1);
            mem_b[bus.Mem_Addr[3:0]] <= bus.Mem_Di;
            n_writes <= n_writes + 1;
        end
        if (bus.Go) n_go <= n_go + 1;
    end

    task automatic check_all_zero(input string phase);
        check({phase, "_in_ready"}, bus.In_Ready, 0);
        check({phase, "_busy"}, bus.Busy, 0);
        check({phase, "_go"}, bus.Go, 0);
        check({phase, "_err"}, bus.Err, 0);
        check({phase, "_a_en_rw"}, {bus.A_En, bus.A_RW}, 0);
        check({phase, "_b_en_rw"}, {bus.B_En, bus.B_RW}, 0);
        check({phase, "_mem_addr"}, bus.Mem_Addr, 0);
        check({phase, "_mem_di"}, bus.Mem_Di, 0);
    endtask

    // mode: 0 ramp 0x00.., 1 random, 2 all 0xFF. gaps: random In_Valid bubbles.
    // spam: stray Start pulses during the load, always on the last data beat.
    task automatic run_load(input int mode, input bit gaps, input bit spam, input bit bad_csum);
        logic [7:0]  data [2*NW+2];
        logic [15:0] sum;
        int          n_beats;
        int          i;
        int          budget;
        int          w0;
        int          g0;
        logic        fire;
        bit          expect_go;

        sum = '0;
        for (int k = 0; k < 2 * NW; k++) begin
            data[k] = (mode == 0) ? 8'(k) : (mode == 1) ? 8'($urandom) : 8'hFF;
            sum = sum + 16'(data[k]);
        end
        if (bad_csum) sum = sum ^ 16'h0001;
        data[2*NW]   = sum[15:8];
        data[2*NW+1] = sum[7:0];
        n_beats   = CsumEn ? 2 * NW + 2 : 2 * NW;
        expect_go = !(CsumEn && bad_csum);

        w0 = n_writes;
        g0 = n_go;
        @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("busy_after_start", bus.Busy, 1);
        check("err_cleared_by_start", bus.Err, 0);

        i = 0;
        budget = 0;
        while (i < n_beats && budget < 40 * n_beats) begin
            bus.In_Valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.In_Data  = bus.In_Valid ? data[i] : 8'($urandom);
            bus.Start    = spam && (($urandom_range(0, 3) == 0) || (i == 2 * NW - 1));
            fire         = bus.In_Valid && bus.In_Ready;
            @(negedge Clk);
            budget++;
            if (fire) i++;
        end
        check("load_beats_accepted", i, n_beats);

        // One cycle after the final beat; offered data here must not be taken.
        bus.Start    = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'($urandom);
        check("go_after_last_beat", bus.Go, 32'(expect_go));
        check("busy_with_go", bus.Busy, 32'(expect_go));
        check("ready_low_after_load", bus.In_Ready, 0);
        check("err_after_load", bus.Err, 32'(!expect_go));
        @(negedge Clk);
        bus.In_Valid = 1'b0;
        check("go_one_cycle", bus.Go, 0);
        check("busy_falls", bus.Busy, 0);
        check("ready_idle", bus.In_Ready, 0);
        check("write_count", n_writes - w0, 2 * NW);
        check("go_count", n_go - g0, 32'(expect_go));
        for (int k = 0; k < NW; k++) begin
            check($sformatf("mem_a[%0d]", k), mem_a[k], data[k]);
            check($sformatf("mem_b[%0d]", k), mem_b[k], data[NW+k]);
        end
    endtask

    initial begin
        int w0;
        int g0;

        bus.Start    = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'hA5;
        Rst_n        = 1'b1;
        #1 Rst_n = 1'b0;
        #2 check_all_zero("reset");
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Idle: offered data is never accepted and nothing is written.
        w0 = n_writes;
        for (int c = 0; c < 10; c++) begin
            bus.In_Valid = 1'b1;
            bus.In_Data  = 8'($urandom);
            @(negedge Clk);
            check("idle_ready_low", bus.In_Ready, 0);
            check("idle_no_en", {bus.A_En, bus.B_En}, 0);
        end
        check("idle_no_writes", n_writes - w0, 0);
        bus.In_Valid = 1'b0;

        run_load(0, 1'b0, 1'b0, 1'b0);
        run_load(0, 1'b1, 1'b0, 1'b0);
        run_load(1, 1'b1, 1'b1, 1'b0);
        repeat (2) run_load(1, 1'b1, 1'b0, 1'b0);

        // Reset after five A beats: outputs drop at once, no Go, clean reload.
        g0 = n_go;
        @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start    = 1'b0;
        bus.In_Valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.In_Data = 8'($urandom);
            @(negedge Clk);
        end
        bus.In_Valid = 1'b0;
        check("addr_after_5_beats", bus.Mem_Addr, 5);
        #2 Rst_n = 1'b0;
        #1 check_all_zero("mid_load_reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        check("no_go_on_reset", n_go - g0, 0);
        run_load(1, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        run_load(2, 1'b0, 1'b0, 1'b0);
        run_load(2, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge Clk);
        check("err_sticky", bus.Err, 1);
        run_load(2, 1'b1, 1'b0, 1'b0);
        run_load(1, 1'b1, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
